// File: rtl/execute_mul_wbqueue_if.sv
// Interface between the MUL return stage, the MUL issue stage and the ROB writeback port.
// The master modport is the writeback queue. The slave modport is the surrounding pipeline.
interface execute_mul_wbqueue_if;
  logic        i_issue_fire;
  logic        o_issue_ready;
  logic        i_valid;
  logic [63:0] i_product;
  logic [3:0]  i_dst_rob;
  logic [7:0]  i_fid;
  logic        i_mul_cmd;
  logic        i_flush;
  logic        o_wb_valid;
  logic        i_wb_ready;
  logic [31:0] o_wb_value;
  logic [3:0]  o_wb_rob;
  logic [7:0]  o_wb_fid;

  modport master (
    input  i_issue_fire, i_valid, i_product, i_dst_rob, i_fid, i_mul_cmd, i_flush, i_wb_ready,
    output o_issue_ready, o_wb_valid, o_wb_value, o_wb_rob, o_wb_fid
  );

  modport slave (
    output i_issue_fire, i_valid, i_product, i_dst_rob, i_fid, i_mul_cmd, i_flush, i_wb_ready,
    input  o_issue_ready, o_wb_valid, o_wb_value, o_wb_rob, o_wb_fid
  );
endinterface

// File: rtl/execute_mul_wbqueue.sv
// Return end of the MUL pipe: selects a product word, queues the results and drives ROB writeback.
// Issue credit covers both queued and in-flight results, so the queue can never overflow.
module execute_mul_wbqueue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  execute_mul_wbqueue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] value;
    logic [3:0]  rob;
    logic [7:0]  fid;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]   credit_used;
  logic             wb_valid;
  logic             push;
  logic             drop;
  logic             pop;

  assign wb_valid = (count_q != '0);
  assign push     = bus.i_valid & ~bus.i_flush & (drop_cnt_q == '0);
  assign drop     = bus.i_valid & ~bus.i_flush & (drop_cnt_q != '0);
  assign pop      = wb_valid & bus.i_wb_ready & ~bus.i_flush;

  always_comb begin
    wr_entry.value = bus.i_mul_cmd ? bus.i_product[63:32] : bus.i_product[31:0];
    wr_entry.rob   = bus.i_dst_rob;
    wr_entry.fid   = bus.i_fid;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    // Every issued op returns exactly once, dropped or not, so inflight ignores flush.
    inflight_d = inflight_q + CNT_W'(bus.i_issue_fire) - CNT_W'(bus.i_valid);

    if (bus.i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = inflight_d;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      drop_cnt_d = drop_cnt_q - CNT_W'(drop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates its visibility, so stale data is harmless.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};

  assign bus.o_issue_ready = (credit_used < (CNT_W+1)'(DEPTH));
  assign bus.o_wb_valid    = wb_valid;
  assign bus.o_wb_value    = head.value;
  assign bus.o_wb_rob      = head.rob;
  assign bus.o_wb_fid      = head.fid;
endmodule

// File: tb/tb_execute_mul_wbqueue.sv
// Directed bench for execute_mul_wbqueue. It covers single ops, backpressure, streaming, both flush cases and mid-run reset.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_execute_mul_wbqueue;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   n_fire;

  execute_mul_wbqueue_if bus ();

  execute_mul_wbqueue #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    logic        cmd;
    logic [31:0] val;
  } vec_t;

  vec_t bp [4] = '{
    '{64'h1111_1111_A0A0_0001, 1'b0, 32'hA0A0_0001},
    '{64'h2222_2222_B0B0_0002, 1'b1, 32'h2222_2222},
    '{64'h3333_3333_C0C0_0003, 1'b0, 32'hC0C0_0003},
    '{64'h4444_4444_D0D0_0004, 1'b1, 32'h4444_4444}
  };

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] val, input logic [3:0] rob,
                          input logic [7:0] fid);
    n_vec++;
    assert ({bus.o_wb_valid, bus.o_wb_value, bus.o_wb_rob, bus.o_wb_fid} === {1'b1, val, rob, fid})
    else begin
      n_err++;
      $error("FAIL %s: observed v=%b %h/%h/%h expected v=1 %h/%h/%h", tag, bus.o_wb_valid,
             bus.o_wb_value, bus.o_wb_rob, bus.o_wb_fid, val, rob, fid);
    end
  endtask

  task automatic arrive(input logic [63:0] prod, input logic cmd, input logic [3:0] rob,
                        input logic [7:0] fid);
    bus.i_valid   = 1'b1;
    bus.i_product = prod;
    bus.i_mul_cmd = cmd;
    bus.i_dst_rob = rob;
    bus.i_fid     = fid;
    cyc();
    bus.i_valid   = 1'b0;
  endtask

  task automatic fire_n(input int n);
    bus.i_issue_fire = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    bus.i_issue_fire = 1'b0;
  endtask

  // Fires while credit is offered, bounded so a stuck ready cannot hang the run.
  task automatic fire_until_full(output int n);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.o_issue_ready) break;
      bus.i_issue_fire = 1'b1;
      cyc();
      n++;
    end
    bus.i_issue_fire = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.i_issue_fire = 1'b0;
    bus.i_valid      = 1'b0;
    bus.i_product    = '0;
    bus.i_dst_rob    = '0;
    bus.i_fid        = '0;
    bus.i_mul_cmd    = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_wb_ready   = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chk1("reset_wb_valid", bus.o_wb_valid, 1'b0);
    chk1("reset_issue_ready", bus.o_issue_ready, 1'b1);

    // Single op, low word, then high word of the same product.
    bus.i_wb_ready = 1'b1;
    fire_n(1);
    bus.i_valid   = 1'b1;
    bus.i_product = 64'h0000_0001_0000_0002;
    bus.i_mul_cmd = 1'b0;
    bus.i_dst_rob = 4'd3;
    bus.i_fid     = 8'h11;
    #1;
    chk1("no_bypass", bus.o_wb_valid, 1'b0);
    cyc();
    bus.i_valid = 1'b0;
    chk_head("single_lo", 32'h0000_0002, 4'd3, 8'h11);
    cyc();
    chk1("single_lo_drained", bus.o_wb_valid, 1'b0);
    fire_n(1);
    arrive(64'h0000_0001_0000_0002, 1'b1, 4'd3, 8'h11);
    chk_head("single_hi", 32'h0000_0001, 4'd3, 8'h11);
    cyc();
    chk1("single_hi_drained", bus.o_wb_valid, 1'b0);

    // Backpressure: credit allows exactly four ops, and the head holds while not ready.
    bus.i_wb_ready = 1'b0;
    fire_until_full(n_fire);
    chk_int("bp_fires", n_fire, 4);
    for (int i = 0; i < 4; i++) arrive(bp[i].prod, bp[i].cmd, 4'(i + 4), 8'(8'h40 + i));
    chk_head("bp_head", bp[0].val, 4'd4, 8'h40);
    chk1("bp_no_credit", bus.o_issue_ready, 1'b0);
    cyc();
    chk_head("bp_head_stable", bp[0].val, 4'd4, 8'h40);
    bus.i_wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("bp_beat%0d", i), bp[i].val, 4'(i + 4), 8'(8'h40 + i));
      cyc();
    end
    chk1("bp_drained", bus.o_wb_valid, 1'b0);
    chk1("bp_credit_back", bus.o_issue_ready, 1'b1);

    // Streaming with a two-cycle multiply: result j arrives at edge j+2 and is popped at edge j+3.
    for (int t = 0; t <= 10; t++) begin
      bus.i_issue_fire = (t < 8);
      bus.i_valid      = (t >= 2 && t < 10);
      if (t >= 2 && t < 10) begin
        bus.i_product = {32'hC000_0000 | 32'(t - 2), 32'h0C00_0000 | 32'(t - 2)};
        bus.i_mul_cmd = 1'((t - 2) % 2);
        bus.i_dst_rob = 4'(t - 2);
        bus.i_fid     = 8'(8'h80 + t - 2);
      end
      if (t < 8) chk1($sformatf("stream_credit%0d", t), bus.o_issue_ready, 1'b1);
      cyc();
      if (t >= 2 && t < 10)
        chk_head($sformatf("stream_beat%0d", t - 2),
                 ((t - 2) % 2 == 1) ? (32'hC000_0000 | 32'(t - 2)) : (32'h0C00_0000 | 32'(t - 2)),
                 4'(t - 2), 8'(8'h80 + t - 2));
    end
    bus.i_issue_fire = 1'b0;
    bus.i_valid      = 1'b0;
    chk1("stream_drained", bus.o_wb_valid, 1'b0);

    // Flush with one queued result, two in flight and one op firing on the flush cycle.
    bus.i_wb_ready = 1'b0;
    fire_n(3);
    arrive(64'h0000_0000_0000_00F1, 1'b0, 4'd9, 8'hF1);
    chk_head("fl_queued", 32'h0000_00F1, 4'd9, 8'hF1);
    bus.i_flush      = 1'b1;
    bus.i_issue_fire = 1'b1;
    cyc();
    bus.i_flush      = 1'b0;
    bus.i_issue_fire = 1'b0;
    chk1("fl_wb_invalid", bus.o_wb_valid, 1'b0);
    bus.i_wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      arrive(64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 4'd1, 8'hEE);
      chk1($sformatf("fl_drop%0d", k), bus.o_wb_valid, 1'b0);
    end
    fire_until_full(n_fire);
    chk_int("fl_credit_restored", n_fire, 4);
    for (int i = 0; i < 4; i++) begin
      arrive(bp[i].prod, bp[i].cmd, 4'(i + 8), 8'(8'h60 + i));
      chk_head($sformatf("fl_after%0d", i), bp[i].val, 4'(i + 8), 8'(8'h60 + i));
    end
    cyc();
    chk1("fl_after_drained", bus.o_wb_valid, 1'b0);

    // Flush coinciding with an arrival and a completing writeback handshake.
    bus.i_wb_ready = 1'b0;
    fire_n(2);
    arrive(64'h0000_0000_0000_00A5, 1'b0, 4'd2, 8'hA5);
    chk_head("flh_queued", 32'h0000_00A5, 4'd2, 8'hA5);
    bus.i_flush    = 1'b1;
    bus.i_wb_ready = 1'b1;
    arrive(64'h0000_0000_0000_00B6, 1'b0, 4'd6, 8'hB6);
    bus.i_flush = 1'b0;
    chk1("flh_wb_invalid", bus.o_wb_valid, 1'b0);
    chk1("flh_issue_ready", bus.o_issue_ready, 1'b1);
    fire_n(1);
    arrive(64'h0000_0007_0000_0000, 1'b1, 4'd7, 8'hC7);
    chk_head("flh_next_op", 32'h0000_0007, 4'd7, 8'hC7);
    cyc();
    chk1("flh_drained", bus.o_wb_valid, 1'b0);

    // Reset with a queued result and ops still in flight.
    bus.i_wb_ready = 1'b0;
    fire_n(3);
    arrive(64'h0000_0000_0000_00D1, 1'b0, 4'd1, 8'hD1);
    chk1("rst_pre_valid", bus.o_wb_valid, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk1("rst_wb_valid", bus.o_wb_valid, 1'b0);
    chk1("rst_issue_ready", bus.o_issue_ready, 1'b1);
    fire_until_full(n_fire);
    chk_int("rst_full_credit", n_fire, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
